rect_fill_controller: RTL and testbench

Sequencer for the shared VGA adapter plot port (160x120, 3-bit colour). It accepts rectangle-fill and clear-screen commands over a valid/ready handshake and emits one pixel write per cycle. It drives the adapter's `x`, `y`, `colour` and `plot` inputs. It sits between the game control FSM and the VGA adapter, and clips rectangles to the visible screen.

---
 rtl/rect_fill_controller.sv | 144 ++++++++++++++
 tb/tb_rect_fill_controller.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rect_fill_controller.sv
// Pixel sequencer for the VGA adapter plot port: accepts rectangle-fill / clear
// commands and streams one clipped pixel write per cycle in raster order.
module rect_fill_controller #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_clear,
  input  logic [7:0] cmd_x,
  input  logic [6:0] cmd_y,
  input  logic [7:0] cmd_w,
  input  logic [6:0] cmd_h,
  input  logic [2:0] cmd_colour,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;

  localparam logic [8:0] X_LIM = 9'(SCREEN_W);
  localparam logic [8:0] Y_LIM = 9'(SCREEN_H);
  localparam logic [8:0] X_MAX = 9'(SCREEN_W - 1);
  localparam logic [8:0] Y_MAX = 9'(SCREEN_H - 1);

  state_t state, state_next;

  logic       c_clear;
  logic [7:0] c_x, c_w;
  logic [6:0] c_y, c_h;
  logic [2:0] c_colour;
  logic [7:0] x0, x1;
  logic [6:0] y0, y1;

  logic [8:0] x_end_raw, y_end_raw;
  logic [7:0] sx0, sx1;
  logic [6:0] sy0, sy1;
  logic       empty, last_col, last_px;

  // Extent arithmetic is 9 bits wide so x+w-1 and y+h-1 never wrap before clipping.
  always_comb begin
    x_end_raw = {1'b0, c_x} + {1'b0, c_w} - 9'd1;
    y_end_raw = {2'b00, c_y} + {2'b00, c_h} - 9'd1;
    empty = !c_clear && (c_w == 8'd0 || c_h == 7'd0 ||
                         {1'b0, c_x} >= X_LIM || {2'b00, c_y} >= Y_LIM);
    sx0 = c_clear ? 8'd0 : c_x;
    sy0 = c_clear ? 7'd0 : c_y;
    if (c_clear || x_end_raw > X_MAX) sx1 = X_MAX[7:0];
    else                              sx1 = x_end_raw[7:0];
    if (c_clear || y_end_raw > Y_MAX) sy1 = Y_MAX[6:0];
    else                              sy1 = y_end_raw[6:0];
    last_col = (x == x1);
    last_px  = last_col && (y == y1);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    plot       = 1'b0;
    done       = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_next = SETUP;
      end
      SETUP: state_next = empty ? DONE : DRAW;
      DRAW: begin
        plot = 1'b1;
        if (last_px) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      c_clear  <= 1'b0;
      c_x      <= '0;
      c_y      <= '0;
      c_w      <= '0;
      c_h      <= '0;
      c_colour <= '0;
      x0       <= '0;
      y0       <= '0;
      x1       <= '0;
      y1       <= '0;
      x        <= '0;
      y        <= '0;
      colour   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            c_clear  <= cmd_clear;
            c_x      <= cmd_x;
            c_y      <= cmd_y;
            c_w      <= cmd_w;
            c_h      <= cmd_h;
            c_colour <= cmd_colour;
          end
        end
        SETUP: begin
          // Outputs are only reloaded for a non-empty command so they hold otherwise.
          if (!empty) begin
            x0     <= sx0;
            y0     <= sy0;
            x1     <= sx1;
            y1     <= sy1;
            x      <= sx0;
            y      <= sy0;
            colour <= c_colour;
          end
        end
        DRAW: begin
          if (!last_col) begin
            x <= x + 8'd1;
          end else if (!last_px) begin
            x <= x0;
            y <= y + 7'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_fill_controller.sv
// Self-checking bench for rect_fill_controller: a per-cycle expectation queue
// built from the clipping rules, plus directed literal checks.
module tb_rect_fill_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_clear;
  logic [7:0] cmd_x, cmd_w;
  logic [6:0] cmd_y, cmd_h;
  logic [2:0] cmd_colour;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, done;

  always #5 clk = ~clk;

  rect_fill_controller #(.SCREEN_W(160), .SCREEN_H(120)) dut (
    .CLOCK_50(clk), .reset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_clear(cmd_clear),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_colour(cmd_colour),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
  );

  typedef struct { bit pl; bit dn; int px; int py; int pc; } exp_t;

  int   checks = 0;
  int   failures = 0;
  exp_t expq[$];
  bit   cur_busy = 1'b0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   acc_count = 0;
  int   done_cyc = -1;
  int   lx[$], ly[$], lc[$], lcy[$];
  bit   seen[19200];

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Model: on accept, enqueue SETUP, each clipped pixel in raster order, then DONE.
  always @(posedge clk) begin
    int xs, ys, xe, ye, col;
    cyc++;
    if (rst) begin
      expq.delete();
    end else if (cmd_valid && !cur_busy) begin
      acc_cyc = cyc;
      acc_count++;
      lx.delete(); ly.delete(); lc.delete(); lcy.delete();
      done_cyc = -1;
      col = int'(cmd_colour);
      if (cmd_clear) begin
        xs = 0; ys = 0; xe = 160; ye = 120;
      end else if (cmd_w == 0 || cmd_h == 0 || cmd_x >= 160 || cmd_y >= 120) begin
        xs = 0; ys = 0; xe = 0; ye = 0;
      end else begin
        xs = int'(cmd_x); ys = int'(cmd_y);
        xe = xs + int'(cmd_w); ye = ys + int'(cmd_h);
        if (xe > 160) xe = 160;
        if (ye > 120) ye = 120;
      end
      expq.push_back('{1'b0, 1'b0, 0, 0, 0});
      for (int yy = ys; yy < ye; yy++)
        for (int xx = xs; xx < xe; xx++)
          expq.push_back('{1'b1, 1'b0, xx, yy, col});
      expq.push_back('{1'b0, 1'b1, 0, 0, 0});
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      cur_busy = 1'b0;
    end else begin
      if (plot === 1'b1) begin
        lx.push_back(int'(x)); ly.push_back(int'(y));
        lc.push_back(int'(colour)); lcy.push_back(cyc);
      end
      if (done === 1'b1) done_cyc = cyc;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        cur_busy = 1'b1;
        chk("plot", int'(plot), int'(e.pl));
        chk("done", int'(done), int'(e.dn));
        chk("busy", int'(busy), 1);
        chk("cmd_ready", int'(cmd_ready), 0);
        if (e.pl) begin
          chk("x", int'(x), e.px);
          chk("y", int'(y), e.py);
          chk("colour", int'(colour), e.pc);
        end
      end else begin
        cur_busy = 1'b0;
        chk("idle_plot", int'(plot), 0);
        chk("idle_done", int'(done), 0);
        chk("idle_busy", int'(busy), 0);
        chk("idle_ready", int'(cmd_ready), 1);
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    @(negedge clk); #1;
    while (cur_busy && k < 30000) begin
      @(negedge clk); #1;
      k++;
    end
    chk("idle_timeout", int'(cur_busy), 0);
  endtask

  task automatic wait_accept(input int target, input int budget);
    int k = 0;
    while (acc_count < target && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    chk("accept_timeout", int'(acc_count >= target), 1);
  endtask

  task automatic wait_done();
    int k = 0;
    while (done_cyc < 0 && k < 30000) begin
      @(negedge clk); #1;
      k++;
    end
    chk("done_timeout", int'(done_cyc >= 0), 1);
  endtask

  task automatic drive(input bit cl, input int xx, input int yy, input int ww,
                       input int hh, input int cc);
    cmd_clear  = cl;
    cmd_x      = 8'(xx);
    cmd_y      = 7'(yy);
    cmd_w      = 8'(ww);
    cmd_h      = 7'(hh);
    cmd_colour = 3'(cc);
  endtask

  task automatic send(input bit cl, input int xx, input int yy, input int ww,
                      input int hh, input int cc);
    int n0;
    wait_idle();
    drive(cl, xx, yy, ww, hh, cc);
    n0 = acc_count;
    cmd_valid = 1'b1;
    wait_accept(n0 + 1, 5);
    cmd_valid = 1'b0;
    wait_done();
  endtask

  initial begin
    int ex[4], ey[4];
    int a1, n0, dups, rx, ry;

    rst = 1'b1;
    cmd_valid = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_x", int'(x), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_colour", int'(colour), 0);
    chk("rst_plot", int'(plot), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    #1 rst = 1'b0;

    // small rectangle
    send(0, 10, 20, 2, 2, 5);
    ex = '{10, 11, 10, 11};
    ey = '{20, 20, 21, 21};
    chk("small_count", lx.size(), 4);
    if (lx.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk("small_x", lx[i], ex[i]);
        chk("small_y", ly[i], ey[i]);
        chk("small_colour", lc[i], 5);
        chk("small_cycle", lcy[i] - acc_cyc + 1, 2 + i);
      end
    chk("small_done_cycle", done_cyc - acc_cyc + 1, 6);
    @(negedge clk); #1;
    chk("small_ready", int'(cmd_ready), 1);
    chk("small_ready_cycle", cyc - acc_cyc + 1, 7);

    // clipping at the bottom-right corner
    send(0, 158, 118, 5, 5, 3);
    ex = '{158, 159, 158, 159};
    ey = '{118, 118, 119, 119};
    chk("clip_count", lx.size(), 4);
    if (lx.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk("clip_x", lx[i], ex[i]);
        chk("clip_y", ly[i], ey[i]);
      end
    chk("clip_done_cycle", done_cyc - acc_cyc + 1, 6);

    // empty commands
    send(0, 30, 30, 0, 7, 1);
    chk("empty_w_plots", lx.size(), 0);
    chk("empty_w_done_cycle", done_cyc - acc_cyc + 1, 2);
    send(0, 200, 10, 4, 4, 1);
    chk("empty_x_plots", lx.size(), 0);
    chk("empty_x_done_cycle", done_cyc - acc_cyc + 1, 2);

    // full-screen clear
    send(1, 77, 33, 9, 9, 0);
    chk("clear_count", lx.size(), 19200);
    if (lx.size() > 0) begin
      chk("clear_first_x", lx[0], 0);
      chk("clear_first_y", ly[0], 0);
      chk("clear_last_x", lx[lx.size()-1], 159);
      chk("clear_last_y", ly[ly.size()-1], 119);
    end
    dups = 0;
    foreach (lx[i]) begin
      if (lx[i] < 160 && ly[i] < 120) begin
        if (seen[ly[i]*160 + lx[i]]) dups++;
        seen[ly[i]*160 + lx[i]] = 1'b1;
      end
    end
    chk("clear_duplicates", dups, 0);

    // reset in the middle of a 10x10 rectangle
    wait_idle();
    drive(0, 20, 30, 10, 10, 4);
    n0 = acc_count;
    cmd_valid = 1'b1;
    wait_accept(n0 + 1, 5);
    cmd_valid = 1'b0;
    begin
      int k = 0;
      @(negedge clk); #1;
      while (lx.size() < 37 && k < 200) begin
        @(negedge clk); #1;
        k++;
      end
      chk("mid_reach_37", int'(lx.size() >= 37), 1);
    end
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_plot", int'(plot), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_ready", int'(cmd_ready), 1);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    send(0, 3, 4, 1, 1, 7);
    chk("post_rst_count", lx.size(), 1);
    if (lx.size() == 1) begin
      chk("post_rst_x", lx[0], 3);
      chk("post_rst_y", ly[0], 4);
    end
    chk("post_rst_done_cycle", done_cyc - acc_cyc + 1, 3);

    // valid held high across two commands
    wait_idle();
    drive(0, 50, 60, 4, 3, 2);
    n0 = acc_count;
    cmd_valid = 1'b1;
    wait_accept(n0 + 1, 5);
    a1 = acc_cyc;
    drive(0, 100, 100, 3, 2, 6);
    wait_accept(n0 + 2, 100);
    cmd_valid = 1'b0;
    chk("held_accept_edge", acc_cyc - a1, 12 + 3);
    wait_done();
    chk("held_b_count", lx.size(), 6);
    if (lx.size() > 0) begin
      chk("held_b_first_x", lx[0], 100);
      chk("held_b_first_y", ly[0], 100);
      chk("held_b_first_cycle", lcy[0] - acc_cyc + 1, 2);
    end
    repeat (5) @(negedge clk);
    chk("held_accepts", acc_count - n0, 2);

    // randomized commands, checked cycle by cycle against the model
    for (int i = 0; i < 40; i++) begin
      rx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(150, 255)) : int'($urandom_range(0, 159));
      ry = ($urandom_range(0, 3) == 0) ? int'($urandom_range(110, 127)) : int'($urandom_range(0, 119));
      send(0, rx, ry, int'($urandom_range(0, 12)), int'($urandom_range(0, 12)),
           int'($urandom_range(0, 7)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
